// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: mul/div op encoding, sequencer FSM states and default width.
package cpu_defs_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the mul/div loop: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_b
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  always_comb begin
    w_sum    = {1'b0, i_acc} + (i_b[0] ? {1'b0, i_a} : '0);
    // Remainder can carry one extra bit after the shift; the trial difference always fits WIDTH bits.
    w_rem_sh = {i_acc, i_b[WIDTH-1]};
    w_ge     = (w_rem_sh >= {1'b0, i_a});
    w_diff   = w_rem_sh[WIDTH-1:0] - i_a;
    o_acc    = w_sum[WIDTH:1];
    o_b      = {w_sum[0], i_b[WIDTH-1:1]};
    if (i_div) begin
      o_acc = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
      o_b   = {i_b[WIDTH-2:0], w_ge};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with EX-stage stall generation.
// Divide datapath is present only when MULDIV_DIV_EN is defined; otherwise divides write zeros.
module muldiv_seq
  import cpu_defs_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hilo_rd,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic             flush_ex,
  output logic             stall_req,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  md_state_e        r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_hi, r_lo;
  logic [CW-1:0]    r_count;
  logic             r_is_div, r_neg_q, r_neg_r, r_direct;

  logic             w_accept, w_signed, w_sa, w_sb, w_direct, w_step_div;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_acc_nx, w_b_nx;
  logic [2*WIDTH-1:0] w_prod;

  // Handshake: start/hilo_rd/hi_wr/lo_wr are held by EX until a cycle with stall_req low;
  // that cycle is the one in which the request is consumed (accepted or written).
  assign w_accept   = (r_state == ST_IDLE) && start && !flush_ex;
  assign w_signed   = md_is_signed(md_op_e'(op));
  assign w_sa       = w_signed & src_a[WIDTH-1];
  assign w_sb       = w_signed & src_b[WIDTH-1];
  assign w_abs_a    = w_sa ? -src_a : src_a;
  assign w_abs_b    = w_sb ? -src_b : src_b;
  assign w_direct   = op[1] && (!DIV_EN || (src_b == '0));
  assign w_step_div = DIV_EN && r_is_div;
  assign w_prod     = {r_acc, r_b};

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div (w_step_div),
    .i_a   (r_a),
    .i_acc (r_acc),
    .i_b   (r_b),
    .o_acc (w_acc_nx),
    .o_b   (w_b_nx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = w_direct ? ST_FIX : ST_RUN;
      ST_RUN:  if (r_count == CW'(WIDTH - 1)) w_next = ST_FIX;
      ST_FIX:  w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_count  <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_direct <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_is_div <= op[1];
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa;
            r_direct <= w_direct;
            r_count  <= '0;
            // Multiply: r_a = multiplicand, r_b = multiplier. Divide: r_a = divisor, r_b = dividend/quotient.
            r_a      <= op[1] ? w_abs_b : w_abs_a;
            r_b      <= op[1] ? w_abs_a : w_abs_b;
            r_acc    <= '0;
            if (w_direct) begin
              r_acc <= DIV_EN ? src_a : '0;
              r_b   <= DIV_EN ? '1 : '0;
            end
          end else if (!flush_ex && !start) begin
            if (hi_wr) r_hi <= src_a;
            if (lo_wr) r_lo <= src_a;
          end
        end
        ST_RUN: begin
          r_acc   <= w_acc_nx;
          r_b     <= w_b_nx;
          r_count <= r_count + CW'(1);
        end
        ST_FIX: begin
          if (r_direct) begin
            r_hi <= r_acc;
            r_lo <= r_b;
          end else if (r_is_div) begin
            r_lo <= r_neg_q ? -r_b : r_b;
            r_hi <= r_neg_r ? -r_acc : r_acc;
          end else begin
            {r_hi, r_lo} <= r_neg_q ? -w_prod : w_prod;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign stall_req = busy && (start || hilo_rd || hi_wr || lo_wr);
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign dbg_state = r_state;

endmodule
